// File: rtl/rom.sv
// rom: 256 x 8 instruction ROM on a shared 4-bit multiplexed bus, with a
// Wishbone backdoor port for loading and reading the memory contents.
// The optional chip I/O port (SRC/WRR/RDR) is built only when the macro
// ROM_IO_PORT_EN is defined; otherwise io_out is tied low and io_in is ignored.
module rom #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    inout  wire  [3:0]  data,
    input  logic        sync,
    input  logic        cmd_n,
    input  logic [3:0]  io_in,
    output logic [3:0]  io_out,
    input  logic [31:0] wb_data_i,
    input  logic [31:0] wb_addr_i,
    input  logic        wb_cyc_i,
    input  logic        wb_strobe_i,
    input  logic        wb_we_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o
);

    // Bus phases of one instruction cycle, taken from the free-running counter
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } phase_t;

    phase_t      cycle;
    logic [7:0]  addr;
    logic        fetch_sel;
    logic [7:0]  mem [0:255];
    logic [7:0]  fetch_byte;
    logic [7:0]  wb_index;
    logic        wb_service;
    logic        op_drive;
    logic [3:0]  op_nibble;
    logic        io_drive;
    logic [3:0]  io_nibble;
    logic        drive_en;
    logic [3:0]  drive_val;
    logic        unused_inputs;

    assign fetch_byte = mem[addr];
    assign wb_index   = wb_addr_i[7:0];

    // Backdoor accesses are only serviced in X3, so they never overlap a fetch
    // read in M1/M2, and at most once per instruction cycle.
    assign wb_service = reset_n && (cycle == X3) && wb_cyc_i && wb_strobe_i && !wb_ack_o;

    // Phase counter, address/chip-select capture and Wishbone response
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle     <= A1;
            addr      <= 8'h00;
            fetch_sel <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_data_o <= 32'h0;
        end else begin
            cycle <= phase_t'(cycle + 3'd1);
            case (cycle)
                A1:      addr[3:0] <= data;
                A2:      addr[7:4] <= data;
                A3:      fetch_sel <= (data == CHIP_ID);
                default: ;
            endcase
            wb_ack_o <= wb_service;
            if (wb_service) begin
                wb_data_o <= {24'h0, mem[wb_index]};
            end
        end
    end

    // Memory array has no reset; only the Wishbone backdoor writes it
    always_ff @(posedge clock) begin
        if (wb_service && wb_we_i) begin
            mem[wb_index] <= wb_data_i[7:0];
        end
    end

    // Opcode nibbles go out high-first in M1/M2 when this chip was addressed
    always_comb begin
        op_drive  = fetch_sel && ((cycle == M1) || (cycle == M2));
        op_nibble = (cycle == M1) ? fetch_byte[7:4] : fetch_byte[3:0];
    end

`ifdef ROM_IO_PORT_EN
    logic        io_sel;
    logic        io_active;
    logic [3:0]  io_op;

    // SRC selects the port, the M2 opcode arms it, and X2 performs WRR
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            io_sel    <= 1'b0;
            io_active <= 1'b0;
            io_op     <= 4'h0;
            io_out    <= 4'h0;
        end else begin
            if (!cmd_n && (cycle == X2)) begin
                io_sel <= (data == CHIP_ID);
            end
            if (!cmd_n && (cycle == M2) && io_sel) begin
                io_op     <= data;
                io_active <= 1'b1;
            end else if (cycle == X3) begin
                io_active <= 1'b0;
            end
            if (io_active && (cycle == X2) && (io_op == 4'h2)) begin
                io_out <= data;
            end
        end
    end

    // RDR places the input pins on the bus during X2
    always_comb begin
        io_drive  = io_active && (cycle == X2) && (io_op == 4'hA);
        io_nibble = io_in;
    end

    assign unused_inputs = ^{sync, wb_addr_i[31:8], wb_data_i[31:8]};
`else
    assign io_out    = 4'h0;
    assign io_drive  = 1'b0;
    assign io_nibble = 4'h0;

    assign unused_inputs = ^{sync, io_in, wb_addr_i[31:8], wb_data_i[31:8]};
`endif

    // Opcode (M1/M2) and RDR (X2) use disjoint phases, so one mux is enough
    always_comb begin
        drive_en  = op_drive || io_drive;
        drive_val = op_drive ? op_nibble : io_nibble;
    end

    assign data = drive_en ? drive_val : 4'bz;

endmodule

// File: tb/tb_rom.sv
// tb_rom: scoreboard bench for rom. The bus has weak pull-ups, so a released
// bus reads back as 4'hF; test nibbles avoid F so that a driven bus is never
// mistaken for a released one.
module tb_rom;

    localparam logic [3:0] CHIP = 4'h7;
`ifdef ROM_IO_PORT_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    wire  [3:0]  data;
    logic        sync;
    logic        cmd_n;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [31:0] wb_data_i;
    logic [31:0] wb_addr_i;
    logic        wb_cyc_i;
    logic        wb_strobe_i;
    logic        wb_we_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o;

    logic        tb_en;
    logic [3:0]  tb_val;

    int vectors;
    int miscompares;

    logic        exp_ack;
    logic        chk_wbdata;
    logic [31:0] exp_wbdata;
    logic        drop_req;
    logic [3:0]  exp_io;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    assign data = tb_en ? tb_val : 4'bz;

    pullup pu0 (data[0]);
    pullup pu1 (data[1]);
    pullup pu2 (data[2]);
    pullup pu3 (data[3]);

    rom #(.CHIP_ID(CHIP)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data        (data),
        .sync        (sync),
        .cmd_n       (cmd_n),
        .io_in       (io_in),
        .io_out      (io_out),
        .wb_data_i   (wb_data_i),
        .wb_addr_i   (wb_addr_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_strobe_i (wb_strobe_i),
        .wb_we_i     (wb_we_i),
        .wb_data_o   (wb_data_o),
        .wb_ack_o    (wb_ack_o)
    );

    always #5 clock = ~clock;

    // Single point of comparison for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int sel, input logic [31:0] e);
        sb_entry_t ent;
        ent.tag = tag;
        ent.sel = sel;
        ent.exp = e;
        sb_q.push_back(ent);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {28'h0, data};
            1:       return {28'h0, io_out};
            2:       return {31'h0, wb_ack_o};
            default: return wb_data_o;
        endcase
    endfunction

    // Drain expectations queued for this clock, sampling on the falling edge
    always @(negedge clock) begin
        sb_entry_t ent;
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            checkOutput(ent.tag, observe(ent.sel), ent.exp);
        end
    end

    // One bus clock: drive the bus, optionally expect a data value, advance
    task automatic phaseStep(input logic en, input logic [3:0] val, input logic cmd,
                             input logic chk, input logic [3:0] expv, input string tag);
        tb_en  = en;
        tb_val = val;
        cmd_n  = ~cmd;
        if (chk) pushExpect(tag, 0, {28'h0, expv});
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic expectWb(input logic ack, input logic chk, input logic [31:0] d, input logic drop);
        exp_ack    = ack;
        chk_wbdata = chk;
        exp_wbdata = d;
        drop_req   = drop;
    endtask

    // One full 8-phase instruction: nibble p of each vector belongs to phase p
    task automatic applyStimulus(input int id, input logic [31:0] nibs, input logic [7:0] drv,
                                 input logic [7:0] cmd, input logic [31:0] expn,
                                 input logic [7:0] chk, input int wb_go);
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin
                pushExpect($sformatf("I%0d.ack", id), 2, {31'h0, exp_ack});
                if (exp_ack && chk_wbdata)
                    pushExpect($sformatf("I%0d.wb_data_o", id), 3, exp_wbdata);
            end
            if (p == 1) begin
                pushExpect($sformatf("I%0d.ack_pulse", id), 2, 32'h0);
                if (drop_req) begin
                    wb_cyc_i    = 1'b0;
                    wb_strobe_i = 1'b0;
                end
            end
            if (p == wb_go) begin
                wb_cyc_i    = 1'b1;
                wb_strobe_i = 1'b1;
            end
            if (p == 7) pushExpect($sformatf("I%0d.io_out", id), 1, {28'h0, exp_io});
            phaseStep(drv[p], nibs[p*4 +: 4], cmd[p], chk[p], expn[p*4 +: 4],
                      $sformatf("I%0d.p%0d.data", id, p));
        end
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        tb_en       = 1'b0;
        tb_val      = 4'h0;
        sync        = 1'b0;
        cmd_n       = 1'b1;
        io_in       = 4'h0;
        wb_data_i   = 32'h0;
        wb_addr_i   = 32'h0;
        wb_cyc_i    = 1'b0;
        wb_strobe_i = 1'b0;
        wb_we_i     = 1'b0;
        exp_io      = 4'h0;
        expectWb(1'b0, 1'b0, 32'h0, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        pushExpect("reset.ack", 2, 32'h0);
        pushExpect("reset.wb_data_o", 3, 32'h0);
        pushExpect("reset.io_out", 1, 32'h0);
        pushExpect("reset.data", 0, 32'hF);
        @(negedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Backdoor write of D5 to 0x3C; upper address/data bits are junk
        wb_addr_i   = 32'hABCD_EF3C;
        wb_data_i   = 32'h1234_56D5;
        wb_we_i     = 1'b1;
        wb_cyc_i    = 1'b1;
        wb_strobe_i = 1'b1;
        applyStimulus(1, 32'h0, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'hFF, -1);

        // Selected fetch of 0x3C: D in M1, 5 in M2, released otherwise
        expectWb(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(2, 32'h0000_073C, 8'h07, 8'h00, 32'hFFF5_DFFF, 8'hF8, -1);

        // Same address, other chip: bus stays released; read request raised in A3
        wb_we_i   = 1'b0;
        wb_addr_i = 32'h5555_AA3C;
        wb_data_i = 32'h0;
        expectWb(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(3, 32'h0000_023C, 8'h07, 8'h00, 32'hFFFF_FFFF, 8'hF8, 2);

        // Read returns D5; strobe held so a second ack arrives 8 clocks later
        expectWb(1'b1, 1'b1, 32'h0000_00D5, 1'b0);
        applyStimulus(4, 32'h0, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'hFF, -1);
        expectWb(1'b1, 1'b1, 32'h0000_00D5, 1'b1);
        applyStimulus(5, 32'h0, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'hFF, -1);
        expectWb(1'b0, 1'b0, 32'h0, 1'b0);

        // SRC to this chip, then WRR 9
        applyStimulus(6, 32'h0700_0000, 8'h47, 8'h40, 32'hFFFF_FFFF, 8'hB8, -1);
        exp_io = IO_EN ? 4'h9 : 4'h0;
        applyStimulus(7, 32'h0902_0000, 8'h57, 8'h10, 32'hFFFF_FFFF, 8'hA8, -1);

        // RDR with io_in=6 drives 6 in X2 only when the port exists
        io_in = 4'h6;
        applyStimulus(8, 32'h000A_0000, 8'h17, 8'h10,
                      IO_EN ? 32'hF6FF_FFFF : 32'hFFFF_FFFF, 8'hE8, -1);

        // SRC to another chip: RDR and WRR are then ignored
        applyStimulus(9, 32'h0300_0000, 8'h47, 8'h40, 32'hFFFF_FFFF, 8'hB8, -1);
        applyStimulus(10, 32'h000A_0000, 8'h17, 8'h10, 32'hFFFF_FFFF, 8'hE8, -1);
        applyStimulus(11, 32'h0402_0000, 8'h57, 8'h10, 32'hFFFF_FFFF, 8'hA8, -1);

        // Reset in M1 of a selected fetch with a Wishbone read pending
        wb_cyc_i    = 1'b1;
        wb_strobe_i = 1'b1;
        phaseStep(1'b1, 4'hC, 1'b0, 1'b0, 4'h0, "R.p0");
        phaseStep(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, "R.p1");
        phaseStep(1'b1, CHIP, 1'b0, 1'b0, 4'h0, "R.p2");
        reset_n = 1'b0;
        phaseStep(1'b0, 4'h0, 1'b0, 1'b1, 4'hD, "R.p3.data");
        reset_n = 1'b1;
        pushExpect("R.io_out", 1, 32'h0);
        pushExpect("R.wb_data_o", 3, 32'h0);
        exp_io = 4'h0;
        expectWb(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(12, 32'h0, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'hFF, -1);
        expectWb(1'b1, 1'b1, 32'h0000_00D5, 1'b1);
        applyStimulus(13, 32'h0, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'hFF, -1);
        expectWb(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(14, 32'h0, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'hFF, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom.md
ROM -- requirements
Module: rom

Interface
REQ-001 Parameter CHIP_ID, default 4'h0, is the chip number matched against the A3 address nibble and the SRC nibble.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 data  inout  4  shared bus carrying address nibbles, opcode nibbles and I/O data.
REQ-005 sync  input  1  bus-cycle marker; accepted but unused, because phase comes from the internal counter.
REQ-006 cmd_n  input  1  active-low ROM command line.
REQ-007 io_in  input  4  I/O port input pins.
REQ-008 io_out  output  4  I/O port output register.
REQ-009 wb_data_i, wb_addr_i  input  32 each  Wishbone backdoor write data and address.
REQ-010 wb_cyc_i, wb_strobe_i, wb_we_i  input  1 each  Wishbone cycle, strobe and write enable.
REQ-011 wb_data_o  output  32  Wishbone read data.
REQ-012 wb_ack_o  output  1  Wishbone acknowledge.

Function
REQ-013 A 3-bit cycle counter SHALL clear on reset and increment by one each clock, wrapping 7->0.
- Phases: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
REQ-014 Address latching SHALL occur at the end of the cycle:
- cycle 0: addr[3:0] <= data.
- cycle 1: addr[7:4] <= data.
- cycle 2: fetch_sel <= (data == CHIP_ID).
REQ-015 Storage SHALL be 256 x 8-bit memory; contents are not altered by reset.
REQ-016 Opcode drive SHALL be combinational, only while fetch_sel=1:
- cycle 3: data = mem[addr][7:4].
- cycle 4: data = mem[addr][3:0].
REQ-017 The block SHALL hold data at high impedance in every other case.
REQ-018 SRC handling SHALL occur when cmd_n=0 at cycle 6:
- io_sel <= (data == CHIP_ID).
- A mismatch clears io_sel.
- io_sel holds until the next SRC or reset.
REQ-019 I/O instruction latching SHALL occur when cmd_n=0 at cycle 4 and io_sel=1: io_op <= data and io_active <= 1.
REQ-020 io_active SHALL clear at the end of cycle 7.
REQ-021 With io_active=1 at cycle 6, io_op SHALL be decoded as follows:
- 4'h2 (WRR): io_out <= data at the end of cycle 6.
- 4'hA (RDR): data = io_in combinationally during cycle 6.
- Any other value: no action.
REQ-022 Data SHALL never be driven by opcode and RDR in the same cycle; the phases are disjoint by construction.
REQ-023 Wishbone servicing SHALL occur at cycle 7, only when wb_cyc_i=1, wb_strobe_i=1 and wb_ack_o=0:
- wb_data_o <= {24'h0, mem[wb_addr_i[7:0]]}.
- If wb_we_i=1: mem[wb_addr_i[7:0]] <= wb_data_i[7:0].
- wb_ack_o <= 1 for exactly one clock.
REQ-024 Wishbone latency SHALL be 1-8 clocks; at most one acknowledge per 8 clocks.
REQ-025 Backdoor writes SHALL occur only in cycle 7, so they never collide with cycle 3/4 fetch reads.
- A write to the address being fetched takes effect from the next instruction cycle.
REQ-026 wb_addr_i[31:8] and wb_data_i[31:8] SHALL be ignored.

Reset
REQ-027 While reset_n=0 at a clock edge, the following SHALL be set:
- cycle=0, addr=8'h00, fetch_sel=0, io_sel=0, io_active=0, io_op=4'h0.
- io_out=4'h0, wb_ack_o=0, wb_data_o=32'h0.
REQ-028 Reset asserted mid-instruction SHALL abort the instruction:
- data released to high impedance on the next clock.
- No pending WRR completes.
- A Wishbone request pending at reset is not acknowledged until a later cycle 7.

Configuration
REQ-029 With macro ROM_IO_PORT_EN defined, the SRC/WRR/RDR logic of REQ-018..REQ-021 SHALL be present.
REQ-030 With ROM_IO_PORT_EN undefined, the I/O logic SHALL be absent:
- io_out is tied to 4'h0.
- io_in is ignored.
- data is never driven at cycle 6.
- Fetch and Wishbone behaviour are unchanged.

Verification
REQ-031 Backdoor-write 8'hD5 to addr 0x3C, then bus cycles 0-2 drive C,3,CHIP_ID -> data=D at cycle 3, data=5 at cycle 4, Z otherwise.
REQ-032 Same fetch but cycle 2 drives a nibble != CHIP_ID -> data is Z for all 8 cycles.
REQ-033 ROM_IO_PORT_EN defined, SRC with CHIP_ID at cycle 6, then cmd_n=0 with M2=2 and data=9 at cycle 6 -> io_out=9 next clock.
- Undefined: io_out stays 0.
REQ-034 SRC to CHIP_ID, io_in=6, M2=A with cmd_n=0 -> data=6 during cycle 6.
- Repeat after SRC to another chip -> data=Z.
REQ-035 Wishbone read of 0x3C asserted at cycle 2 -> ack at clock after cycle 7, wb_data_o=32'hD5.
- Strobe held -> next ack 8 clocks later.
REQ-036 Assert reset_n=0 at cycle 3 of a selected fetch -> next clock data=Z, cycle=0, io_out=0, wb_ack_o=0.
